spike_rate_encoder: RTL and testbench
=====================================

// Module: spike_rate_encoder
// PURPOSE
//  Input-side counterpart of the output winner/readout stage: converts one sample of
//  NUM_INPUTS unsigned intensities into NUM_STEPS timesteps of per-channel spike trains
//  that drive the first neuron layer. Rate coding: a channel's spike probability (or
//  exact spike count) is proportional to its intensity.
//  Timesteps advance only on step_en_i, so the network controls pacing.
// PARAMETERS
//  NUM_INPUTS  16       number of input channels / spike lines
//  DATA_W      8        intensity width per channel (unsigned)
//  NUM_STEPS   32       timesteps per sample (>=1)
//  LFSR_W      16       per-channel LFSR width (>= DATA_W)
//  SEED        16'hACE1 base LFSR seed
// PORTS
//  clk_i          in   1                  clock, all state on rising edge
//  rst_ni         in   1                  reset, asynchronous, active-low
//  data_valid_i   in   1                  sample offered
//  data_ready_o   out  1                  encoder can accept a sample
//  data_i         in   NUM_INPUTS*DATA_W  channel i = data_i[i*DATA_W +: DATA_W]
//  mode_i         in   1                  0 = stochastic (LFSR), 1 = deterministic (accumulator)
//  step_en_i      in   1                  advance one timestep
//  abort_i        in   1                  cancel current sample
//  spikes_o       out  NUM_INPUTS         spike vector, valid with spike_valid_o
//  spike_valid_o  out  1                  one-cycle pulse per executed timestep
//  busy_o         out  1                  sample in progress
//  done_o         out  1                  one-cycle pulse with the final timestep
// BEHAVIOUR
//  - Reset (rst_ni=0, async): state IDLE; data_ready_o=1; spikes_o=0; spike_valid_o=0;
//    busy_o=0; done_o=0; step counter, accumulators and LFSRs cleared/reseeded.
//  - FSM IDLE: data_ready_o=1. Handshake data_valid_i&data_ready_o captures data_i and
//    mode_i, zeroes accumulators, reseeds every LFSR, clears step_cnt, then goes to RUN.
//  - FSM RUN: data_ready_o=0, busy_o=1. A cycle with step_en_i=1 executes one timestep.
//    spikes_o/spike_valid_o are registered one cycle later (latency 1).
//  - Step with step_cnt == NUM_STEPS-1: done_o pulses together with that step's
//    spike_valid_o; the FSM returns to IDLE on the same edge.
//  - Outputs outside a timestep: spikes_o=0 whenever spike_valid_o=0.
//  - Stochastic mode: spike[i] = (lfsr_i[DATA_W-1:0] < val_i). Each LFSR advances once
//    per executed step. Seed_i = SEED ^ (i*16'h9E37) truncated to LFSR_W; forced to 1 if
//    the result is 0.
//  - Deterministic mode: sum = {1'b0,acc_i} + val_i (DATA_W+1 bits); spike[i] = sum[DATA_W];
//    acc_i <= sum[DATA_W-1:0]. Spike count after k steps = floor(k*val_i / 2^DATA_W).
//  - Edge values: val 0 never spikes in either mode. val 2^DATA_W-1 does not spike on
//    step 0 in deterministic mode.
//  - step_en_i is ignored in IDLE. data_valid_i is ignored in RUN and is not captured.
//  - abort_i in RUN: return to IDLE next edge; no done_o; a pending step is discarded
//    (spike_valid_o stays 0).
//  - abort_i has priority over step_en_i in the same cycle. abort_i in IDLE has no effect.
//  - step_cnt width $clog2(NUM_STEPS+1); no wrap, since the FSM exits at NUM_STEPS.
// STRUCTURE
//  - snn_pkg: enc_mode_e {ENC_STOCHASTIC, ENC_DETERMINISTIC}, enc_state_e {ENC_IDLE, ENC_RUN}.
//  - Sub-module spike_lfsr #(LFSR_W, taps 16'hB400 Galois): ports seed_i, load_i, adv_i,
//    state_o; one instance per channel via generate.
//  - Top holds the FSM, step counter, value/accumulator registers and comparators.
// TESTING
//  1 Reset mid-RUN (rst_ni low at step 10) -> all outputs 0 immediately; data_ready_o=1
//    after release; next sample runs a full 32 steps.
//  2 Deterministic, ch0=128, ch1=255, ch2=0, ch3=64, step_en_i held 1 -> counts 16/31/0/8.
//    ch0 spikes on odd steps only; done_o coincides with the 32nd spike_valid_o.
//  3 Deterministic, step_en_i toggled 1010... -> exactly 32 spike_valid_o pulses, each 1
//    cycle after a step_en_i; counts identical to test 2.
//  4 Stochastic, same sample run twice -> identical spike vectors each step (reseed).
//    ch=0 never spikes. ch=255 count >= 28 of 32.
//  5 abort_i asserted with step_en_i at step 5 -> no spike_valid_o that cycle, no done_o;
//    data_ready_o=1 next cycle.
//  6 data_valid_i during RUN with new data -> ignored; the counts of the running sample
//    are unchanged.

Source files
------------

// File: rtl/snn_pkg.sv
// Shared types and helpers for the spiking-network front end.
package snn_pkg;

    typedef enum logic {
        ENC_STOCHASTIC    = 1'b0,
        ENC_DETERMINISTIC = 1'b1
    } enc_mode_e;

    typedef enum logic {
        ENC_IDLE = 1'b0,
        ENC_RUN  = 1'b1
    } enc_state_e;

    // Galois feedback mask for the 16-bit maximal-length polynomial x^16+x^14+x^13+x^11+1.
    localparam logic [15:0] LFSR_TAPS_16 = 16'hB400;

    // Spreads the base seed across channels so neighbouring lanes start decorrelated.
    function automatic logic [31:0] lfsrSeedRaw(input logic [31:0] baseSeed, input int unsigned idx);
        return baseSeed ^ (idx * 32'h0000_9E37);
    endfunction

endpackage

// File: rtl/spike_lfsr.sv
// Per-channel Galois LFSR used as the random source for stochastic rate coding.
module spike_lfsr
    import snn_pkg::*;
#(
    parameter int                LFSR_W   = 16,
    parameter logic [LFSR_W-1:0] TAPS     = LFSR_W'(LFSR_TAPS_16),
    parameter logic [LFSR_W-1:0] RST_SEED = LFSR_W'(1)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [LFSR_W-1:0] seed_i,
    input  logic              load_i,
    input  logic              adv_i,
    output logic [LFSR_W-1:0] state_o
);

    logic [LFSR_W-1:0] state_q;
    logic [LFSR_W-1:0] state_d;

    // Loading a seed wins over advancing; a right shift folds the dropped bit back through the taps.
    always_comb begin
        state_d = state_q;
        if (load_i) begin
            state_d = seed_i;
        end else if (adv_i) begin
            state_d = (state_q >> 1) ^ (state_q[0] ? TAPS : '0);
        end
    end

    // State register, reseeded to a nonzero constant on reset so it can never lock up.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= RST_SEED;
        end else begin
            state_q <= state_d;
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/spike_rate_encoder.sv
// Rate encoder: turns one sample of channel intensities into NUM_STEPS timesteps of spikes.
module spike_rate_encoder
    import snn_pkg::*;
#(
    parameter int                NUM_INPUTS = 16,
    parameter int                DATA_W     = 8,
    parameter int                NUM_STEPS  = 32,
    parameter int                LFSR_W     = 16,
    parameter logic [LFSR_W-1:0] SEED       = LFSR_W'(16'hACE1)
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         data_valid_i,
    output logic                         data_ready_o,
    input  logic [NUM_INPUTS*DATA_W-1:0] data_i,
    input  logic                         mode_i,
    input  logic                         step_en_i,
    input  logic                         abort_i,
    output logic [NUM_INPUTS-1:0]        spikes_o,
    output logic                         spike_valid_o,
    output logic                         busy_o,
    output logic                         done_o
);

    localparam int CNT_W = $clog2(NUM_STEPS + 1);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(NUM_STEPS - 1);

    enc_state_e state_q, state_d;
    enc_mode_e  mode_q,  mode_d;

    logic [CNT_W-1:0]                   stepCnt_q, stepCnt_d;
    logic [NUM_INPUTS-1:0][DATA_W-1:0]  val_q, val_d;
    logic [NUM_INPUTS-1:0][DATA_W-1:0]  acc_q, acc_d;
    logic [NUM_INPUTS-1:0]              spikes_q, spikes_d;
    logic                               spikeValid_q, spikeValid_d;
    logic                               done_q, done_d;

    logic [NUM_INPUTS-1:0][LFSR_W-1:0]  lfsrState;
    logic [NUM_INPUTS-1:0][DATA_W:0]    accSum;
    logic [NUM_INPUTS-1:0]              stepSpikes;
    logic                               lfsrLoad;
    logic                               lfsrAdv;

    for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_chan
        localparam logic [31:0]       RAW_SEED   = lfsrSeedRaw(32'(SEED), gi);
        localparam logic [LFSR_W-1:0] TRUNC_SEED = LFSR_W'(RAW_SEED);
        localparam logic [LFSR_W-1:0] CHAN_SEED  = (TRUNC_SEED == '0) ? LFSR_W'(1) : TRUNC_SEED;

        spike_lfsr #(
            .LFSR_W   (LFSR_W),
            .TAPS     (LFSR_W'(LFSR_TAPS_16)),
            .RST_SEED (CHAN_SEED)
        ) u_lfsr (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .seed_i  (CHAN_SEED),
            .load_i  (lfsrLoad),
            .adv_i   (lfsrAdv),
            .state_o (lfsrState[gi])
        );

        // The accumulator carry-out is the deterministic spike; the low bits are the running remainder.
        assign accSum[gi]     = {1'b0, acc_q[gi]} + {1'b0, val_q[gi]};
        assign stepSpikes[gi] = (mode_q == ENC_DETERMINISTIC) ? accSum[gi][DATA_W]
                                                              : (lfsrState[gi][DATA_W-1:0] < val_q[gi]);
    end

    // Sequencing: capture a sample in IDLE, execute paced timesteps in RUN, abort beats a pending step.
    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        stepCnt_d    = stepCnt_q;
        val_d        = val_q;
        acc_d        = acc_q;
        spikes_d     = '0;
        spikeValid_d = 1'b0;
        done_d       = 1'b0;
        lfsrLoad     = 1'b0;
        lfsrAdv      = 1'b0;

        case (state_q)
            ENC_IDLE: begin
                if (data_valid_i) begin
                    val_d     = data_i;
                    mode_d    = mode_i ? ENC_DETERMINISTIC : ENC_STOCHASTIC;
                    acc_d     = '0;
                    stepCnt_d = '0;
                    lfsrLoad  = 1'b1;
                    state_d   = ENC_RUN;
                end
            end
            ENC_RUN: begin
                if (abort_i) begin
                    state_d = ENC_IDLE;
                end else if (step_en_i) begin
                    spikes_d     = stepSpikes;
                    spikeValid_d = 1'b1;
                    lfsrAdv      = 1'b1;
                    stepCnt_d    = stepCnt_q + CNT_W'(1);
                    if (mode_q == ENC_DETERMINISTIC) begin
                        for (int i = 0; i < NUM_INPUTS; i++) begin
                            acc_d[i] = accSum[i][DATA_W-1:0];
                        end
                    end
                    if (stepCnt_q == LAST_STEP) begin
                        done_d  = 1'b1;
                        state_d = ENC_IDLE;
                    end
                end
            end
            default: begin
                state_d = ENC_IDLE;
            end
        endcase
    end

    // All encoder state and the registered spike outputs; reset returns to an empty IDLE.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ENC_IDLE;
            mode_q       <= ENC_STOCHASTIC;
            stepCnt_q    <= '0;
            val_q        <= '0;
            acc_q        <= '0;
            spikes_q     <= '0;
            spikeValid_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            stepCnt_q    <= stepCnt_d;
            val_q        <= val_d;
            acc_q        <= acc_d;
            spikes_q     <= spikes_d;
            spikeValid_q <= spikeValid_d;
            done_q       <= done_d;
        end
    end

    assign data_ready_o  = (state_q == ENC_IDLE);
    assign busy_o        = (state_q == ENC_RUN);
    assign spikes_o      = spikes_q;
    assign spike_valid_o = spikeValid_q;
    assign done_o        = done_q;

endmodule

// File: tb/tb_spike_rate_encoder.sv
// Self-checking bench for spike_rate_encoder with a reference model and an expectation queue.
module tb_spike_rate_encoder;

    localparam int NIN   = 16;
    localparam int DW    = 8;
    localparam int STEPS = 32;

    logic            clk;
    logic            rstN;
    logic            dataValid;
    logic            dataReady;
    logic [NIN*DW-1:0] dataIn;
    logic            modeIn;
    logic            stepEn;
    logic            abortReq;
    logic [NIN-1:0]  spikes;
    logic            spikeValid;
    logic            busy;
    logic            done;

    spike_rate_encoder dut (
        .clk_i         (clk),
        .rst_ni        (rstN),
        .data_valid_i  (dataValid),
        .data_ready_o  (dataReady),
        .data_i        (dataIn),
        .mode_i        (modeIn),
        .step_en_i     (stepEn),
        .abort_i       (abortReq),
        .spikes_o      (spikes),
        .spike_valid_o (spikeValid),
        .busy_o        (busy),
        .done_o        (done)
    );

    // Free-running 100 MHz clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model state.
    bit          tbRun;
    int          tbStep;
    bit          mMode;
    logic [7:0]  mVal  [NIN];
    logic [7:0]  mAcc  [NIN];
    logic [15:0] mLfsr [NIN];
    logic [16:0] expQ  [$];

    // Observed statistics for the current sample.
    int          spikeCnt [NIN];
    int          validCnt;
    int          traceIdx;
    logic [15:0] trace    [STEPS];
    logic [15:0] firstRun [STEPS];

    logic [NIN*DW-1:0] detData;
    logic [NIN*DW-1:0] altData;
    logic [NIN*DW-1:0] stochData;

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%0h expected=%0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] seedOf(input int idx);
        logic [15:0] s;
        s = 16'hACE1 ^ 16'(idx * 32'h9E37);
        if (s == 16'h0) s = 16'h1;
        return s;
    endfunction

    // Drives one cycle of inputs, predicts the effect of the coming edge, then checks the outputs.
    task automatic applyStimulus(input bit valid, input bit se, input bit ab,
                                 input logic [NIN*DW-1:0] d, input bit m);
        logic [15:0] sp;
        logic [8:0]  sum;
        logic [16:0] e;
        bit          expValid;
        dataValid = valid;
        stepEn    = se;
        abortReq  = ab;
        dataIn    = d;
        modeIn    = m;
        if (!tbRun) begin
            if (valid) begin
                mMode = m;
                for (int i = 0; i < NIN; i++) begin
                    mVal[i]  = d[i*DW +: DW];
                    mAcc[i]  = 8'h0;
                    mLfsr[i] = seedOf(i);
                end
                tbStep = 0;
                tbRun  = 1'b1;
            end
        end else if (ab) begin
            tbRun = 1'b0;
        end else if (se) begin
            for (int i = 0; i < NIN; i++) begin
                if (mMode) begin
                    sum     = {1'b0, mAcc[i]} + {1'b0, mVal[i]};
                    sp[i]   = sum[8];
                    mAcc[i] = sum[7:0];
                end else begin
                    sp[i] = (mLfsr[i][7:0] < mVal[i]);
                end
                mLfsr[i] = (mLfsr[i] >> 1) ^ (mLfsr[i][0] ? 16'hB400 : 16'h0);
            end
            expQ.push_back({(tbStep == STEPS - 1), sp});
            tbStep++;
            if (tbStep == STEPS) tbRun = 1'b0;
        end
        @(posedge clk);
        #1;
        expValid = (expQ.size() > 0);
        checkOutput("spikeValid", {31'b0, spikeValid}, {31'b0, expValid});
        if (expValid) begin
            e = expQ.pop_front();
            checkOutput("spikes", {16'b0, spikes}, {16'b0, e[15:0]});
            checkOutput("done", {31'b0, done}, {31'b0, e[16]});
        end else begin
            checkOutput("spikesIdle", {16'b0, spikes}, 32'h0);
            checkOutput("doneIdle", {31'b0, done}, 32'h0);
        end
        checkOutput("dataReady", {31'b0, dataReady}, {31'b0, !tbRun});
        checkOutput("busy", {31'b0, busy}, {31'b0, tbRun});
        if (spikeValid) begin
            validCnt++;
            for (int i = 0; i < NIN; i++) spikeCnt[i] += int'(spikes[i]);
            if (traceIdx < STEPS) trace[traceIdx] = spikes;
            traceIdx++;
        end
    endtask

    task automatic clearStats();
        validCnt = 0;
        traceIdx = 0;
        for (int i = 0; i < NIN; i++) spikeCnt[i] = 0;
    endtask

    // pattern: 0 = step every cycle, 1 = step on alternate cycles, 2 = step every cycle with a competing sample offered
    task automatic runSample(input logic [NIN*DW-1:0] d, input bit m, input int pattern);
        int cyc;
        clearStats();
        applyStimulus(1'b1, 1'b0, 1'b0, d, m);
        cyc = 0;
        while (tbRun && cyc < 200) begin
            if (pattern == 1)
                applyStimulus(1'b0, (cyc % 2) == 0, 1'b0, d, m);
            else if (pattern == 2)
                applyStimulus(1'b1, 1'b1, 1'b0, altData, 1'b0);
            else
                applyStimulus(1'b0, 1'b1, 1'b0, d, m);
            cyc++;
        end
        checkOutput("sampleInBudget", {31'b0, tbRun}, 32'h0);
        checkOutput("validPulses", validCnt, STEPS);
    endtask

    task automatic checkDetCounts(input string tag);
        checkOutput({tag, "_cnt128"}, spikeCnt[0], 16);
        checkOutput({tag, "_cnt255"}, spikeCnt[1], 31);
        checkOutput({tag, "_cnt0"},   spikeCnt[2], 0);
        checkOutput({tag, "_cnt64"},  spikeCnt[3], 8);
    endtask

    initial begin
        for (int i = 0; i < NIN; i++) begin
            detData[i*DW +: DW]   = 8'(i * 23 + 7);
            altData[i*DW +: DW]   = 8'(255 - i * 11);
            stochData[i*DW +: DW] = 8'(i * 16 + 5);
        end
        detData[0*DW +: DW]   = 8'd128;
        detData[1*DW +: DW]   = 8'd255;
        detData[2*DW +: DW]   = 8'd0;
        detData[3*DW +: DW]   = 8'd64;
        stochData[0*DW +: DW] = 8'd0;
        stochData[1*DW +: DW] = 8'd255;

        tbRun     = 1'b0;
        tbStep    = 0;
        dataValid = 1'b0;
        stepEn    = 1'b0;
        abortReq  = 1'b0;
        dataIn    = '0;
        modeIn    = 1'b0;
        rstN      = 1'b0;
        #12;
        checkOutput("rstReady", {31'b0, dataReady}, 32'h1);
        checkOutput("rstBusy", {31'b0, busy}, 32'h0);
        checkOutput("rstValid", {31'b0, spikeValid}, 32'h0);
        checkOutput("rstSpikes", {16'b0, spikes}, 32'h0);
        checkOutput("rstDone", {31'b0, done}, 32'h0);
        @(negedge clk);
        rstN = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] step_en in IDLE is ignored");
        applyStimulus(1'b0, 1'b1, 1'b0, detData, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1, detData, 1'b1);

        $display("[TB] reset in the middle of a run");
        clearStats();
        applyStimulus(1'b1, 1'b0, 1'b0, detData, 1'b1);
        for (int k = 0; k < 10; k++) applyStimulus(1'b0, 1'b1, 1'b0, detData, 1'b1);
        checkOutput("preRstSteps", validCnt, 10);
        #2;
        rstN = 1'b0;
        #1;
        checkOutput("midRstValid", {31'b0, spikeValid}, 32'h0);
        checkOutput("midRstSpikes", {16'b0, spikes}, 32'h0);
        checkOutput("midRstBusy", {31'b0, busy}, 32'h0);
        checkOutput("midRstDone", {31'b0, done}, 32'h0);
        checkOutput("midRstReady", {31'b0, dataReady}, 32'h1);
        tbRun = 1'b0;
        expQ.delete();
        @(negedge clk);
        rstN = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("postRstReady", {31'b0, dataReady}, 32'h1);
        runSample(detData, 1'b1, 0);

        $display("[TB] deterministic, step_en held");
        runSample(detData, 1'b1, 0);
        checkDetCounts("held");
        for (int k = 0; k < STEPS; k++) begin
            checkOutput("ch128Parity", {31'b0, trace[k][0]}, k % 2);
        end

        $display("[TB] deterministic, step_en toggled");
        runSample(detData, 1'b1, 1);
        checkDetCounts("toggle");

        $display("[TB] stochastic, same sample twice");
        runSample(stochData, 1'b0, 0);
        for (int k = 0; k < STEPS; k++) firstRun[k] = trace[k];
        checkOutput("stochZero", spikeCnt[0], 0);
        checkOutput("stochFull", {31'b0, spikeCnt[1] >= 28}, 32'h1);
        runSample(stochData, 1'b0, 0);
        for (int k = 0; k < STEPS; k++) begin
            checkOutput("stochRepeat", {16'b0, trace[k]}, {16'b0, firstRun[k]});
        end

        $display("[TB] abort together with step_en");
        clearStats();
        applyStimulus(1'b1, 1'b0, 1'b0, detData, 1'b1);
        for (int k = 0; k < 5; k++) applyStimulus(1'b0, 1'b1, 1'b0, detData, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1, detData, 1'b1);
        checkOutput("abortValid", {31'b0, spikeValid}, 32'h0);
        checkOutput("abortDone", {31'b0, done}, 32'h0);
        checkOutput("abortReady", {31'b0, dataReady}, 32'h1);
        checkOutput("abortSteps", validCnt, 5);
        applyStimulus(1'b0, 1'b1, 1'b0, detData, 1'b1);

        $display("[TB] new sample offered during a run");
        runSample(detData, 1'b1, 2);
        checkDetCounts("interfere");

        dataValid = 1'b0;
        stepEn    = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, detData, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
